// File: rtl/lcd_sequencer.sv
// Character-LCD front end: runs the HD44780 init sequence, then turns a valid/ready
// character stream into data writes plus the cursor-address commands for wrap/newline/clear.
module lcd_sequencer #(
    parameter int unsigned COLS       = 16,
    parameter logic [6:0]  LINE1_ADDR = 7'h40
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CHAR_VALID,
    input  logic [7:0] CHAR_DATA,
    output logic       CHAR_READY,
    output logic       LCD_WRITE,
    output logic [8:0] LCD_WRDATA,
    input  logic       LCD_STATUS,
    output logic       INIT_DONE,
    output logic [4:0] CURSOR_COL,
    output logic       CURSOR_LINE
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_IDLE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [8:0] seq0_q, seq0_d;
    logic [8:0] seq1_q, seq1_d;
    logic       two_q, two_d;
    logic [4:0] ncol_q, ncol_d;
    logic       nline_q, nline_d;
    logic       ready_q, ready_d;
    logic       write_q, write_d;
    logic [8:0] wrdata_q, wrdata_d;
    logic       done_q, done_d;
    logic [4:0] col_q, col_d;
    logic       line_q, line_d;

    logic [8:0] cur_word;
    logic       is_last;

    function automatic logic [8:0] init_rom(input logic [2:0] i);
        case (i)
            3'd0:    return 9'h038;
            3'd1:    return 9'h00C;
            3'd2:    return 9'h001;
            3'd3:    return 9'h006;
            default: return 9'h080;
        endcase
    endfunction

    function automatic logic [8:0] line_cmd(input logic ln);
        return ln ? {2'b01, LINE1_ADDR} : 9'h080;
    endfunction

    // During init the word comes from the fixed table; afterwards from the captured sequence.
    always_comb begin
        cur_word = done_q ? (idx_q[0] ? seq1_q : seq0_q) : init_rom(idx_q);
        is_last  = done_q ? (idx_q[0] == two_q) : (idx_q == 3'd4);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seq0_d   = seq0_q;
        seq1_d   = seq1_q;
        two_d    = two_q;
        ncol_d   = ncol_q;
        nline_d  = nline_q;
        write_d  = 1'b0;
        wrdata_d = wrdata_q;
        done_d   = done_q;
        col_d    = col_q;
        line_d   = line_q;

        case (state_q)
            S_ISSUE: begin
                if (!LCD_STATUS) begin
                    write_d  = 1'b1;
                    wrdata_d = cur_word;
                    if (done_q && is_last) begin
                        col_d  = ncol_q;
                        line_d = nline_q;
                    end
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (LCD_STATUS) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!LCD_STATUS) begin
                    if (is_last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_IDLE: begin
                if (CHAR_VALID && ready_q) begin
                    idx_d   = '0;
                    state_d = S_ISSUE;
                    seq1_d  = '0;
                    two_d   = 1'b0;
                    case (CHAR_DATA)
                        8'h0C: begin
                            seq0_d  = 9'h001;
                            seq1_d  = 9'h080;
                            two_d   = 1'b1;
                            ncol_d  = '0;
                            nline_d = 1'b0;
                        end
                        8'h0A: begin
                            seq0_d  = line_cmd(~line_q);
                            ncol_d  = '0;
                            nline_d = ~line_q;
                        end
                        8'h0D: begin
                            seq0_d  = line_cmd(line_q);
                            ncol_d  = '0;
                            nline_d = line_q;
                        end
                        default: begin
                            seq0_d = {1'b1, CHAR_DATA};
                            if (col_q == 5'(COLS - 1)) begin
                                seq1_d  = line_cmd(~line_q);
                                two_d   = 1'b1;
                                ncol_d  = '0;
                                nline_d = ~line_q;
                            end else begin
                                ncol_d  = col_q + 5'd1;
                                nline_d = line_q;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_ISSUE;
        endcase

        ready_d = (state_d == S_IDLE) && done_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_ISSUE;
            idx_q    <= '0;
            seq0_q   <= '0;
            seq1_q   <= '0;
            two_q    <= 1'b0;
            ncol_q   <= '0;
            nline_q  <= 1'b0;
            ready_q  <= 1'b0;
            write_q  <= 1'b0;
            wrdata_q <= '0;
            done_q   <= 1'b0;
            col_q    <= '0;
            line_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            seq0_q   <= seq0_d;
            seq1_q   <= seq1_d;
            two_q    <= two_d;
            ncol_q   <= ncol_d;
            nline_q  <= nline_d;
            ready_q  <= ready_d;
            write_q  <= write_d;
            wrdata_q <= wrdata_d;
            done_q   <= done_d;
            col_q    <= col_d;
            line_q   <= line_d;
        end
    end

    assign CHAR_READY  = ready_q;
    assign LCD_WRITE   = write_q;
    assign LCD_WRDATA  = wrdata_q;
    assign INIT_DONE   = done_q;
    assign CURSOR_COL  = col_q;
    assign CURSOR_LINE = line_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: LCD controller busy model, strobe monitor and a
// cursor/command reference model driven by directed and random characters.
module tb_lcd_sequencer;
    localparam int COLS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       wr;
    logic [8:0] wrdata;
    logic       status;
    logic       done;
    logic [4:0] col;
    logic       line;

    logic       hold_busy = 1'b1;
    int         busy_len  = 20;
    int         busy_cnt  = 0;
    int         total     = 0;
    int         bad       = 0;
    int         viol      = 0;
    logic       prev_wr   = 1'b0;
    logic       prev_st   = 1'b0;
    logic [8:0] strobes[$];
    logic [8:0] expq[$];
    int         m_col     = 0;
    int         m_line    = 0;

    always #5 clk = ~clk;

    lcd_sequencer #(.COLS(COLS), .LINE1_ADDR(7'h40)) dut (
        .CLK        (clk),
        .RST        (rst),
        .CHAR_VALID (valid),
        .CHAR_DATA  (data),
        .CHAR_READY (ready),
        .LCD_WRITE  (wr),
        .LCD_WRDATA (wrdata),
        .LCD_STATUS (status),
        .INIT_DONE  (done),
        .CURSOR_COL (col),
        .CURSOR_LINE(line)
    );

    // Controller model: busy for busy_len cycles after each strobe, or forced busy.
    always @(posedge clk) begin
        if (wr) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign status = hold_busy || (busy_cnt != 0);

    // A strobe must never follow a strobe or be issued while the controller was busy.
    always @(posedge clk) begin
        if (wr) begin
            strobes.push_back(wrdata);
            if (prev_wr || prev_st) viol <= viol + 1;
        end
        prev_wr <= wr;
        prev_st <= status;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int base);
        logic [31:0] got;
        chk({tag, "_len"}, strobes.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            got = (base + i < strobes.size()) ? {23'd0, strobes[base + i]} : 32'hFFFF_FFFF;
            chk(tag, got, {23'd0, expq[i]});
        end
    endtask

    task automatic model_char(input logic [7:0] c);
        expq.delete();
        if (c == 8'h0C) begin
            expq.push_back(9'h001);
            expq.push_back(9'h080);
            m_col = 0;
            m_line = 0;
        end else if (c == 8'h0A) begin
            m_line = 1 - m_line;
            m_col = 0;
            expq.push_back(9'(128 + 64 * m_line));
        end else if (c == 8'h0D) begin
            m_col = 0;
            expq.push_back(9'(128 + 64 * m_line));
        end else begin
            expq.push_back(9'(256 + int'(c)));
            m_col = m_col + 1;
            if (m_col == COLS) begin
                m_col = 0;
                m_line = 1 - m_line;
                expq.push_back(9'(128 + 64 * m_line));
            end
        end
    endtask

    task automatic init_list();
        expq.delete();
        expq.push_back(9'h038);
        expq.push_back(9'h00C);
        expq.push_back(9'h001);
        expq.push_back(9'h006);
        expq.push_back(9'h080);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_char(input logic [7:0] c, input int hold);
        int base;
        int n;
        int early;
        wait_ready();
        chk("ready_before_send", ready, 1);
        model_char(c);
        base = strobes.size();
        if (hold > 0) hold_busy = 1'b1;
        valid = 1'b1;
        data  = c;
        @(negedge clk);
        chk("ready_drop", ready, 0);
        valid = 1'b1;
        data  = 8'($urandom);
        if (hold > 0) begin
            early = 0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (wr) early++;
            end
            chk("strobe_while_busy", early, 0);
            hold_busy = 1'b0;
        end else begin
            @(negedge clk);
            chk("latency2", wr, 1);
        end
        n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            valid = 1'b1;
            data  = 8'($urandom);
            n++;
        end
        valid = 1'b0;
        chk("seq_complete", ready, 1);
        chk_seq("seq", base);
        chk("col", col, m_col);
        chk("line", line, m_line);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr"}, wr, 0);
        chk({tag, "_wrdata"}, wrdata, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_line"}, line, 0);
    endtask

    task automatic run_init(input string tag);
        int base;
        int n;
        int early;
        base = strobes.size();
        n = 0;
        early = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            if (ready && !done) early++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ready_early"}, early, 0);
        init_list();
        chk_seq({tag, "_cmds"}, base);
    endtask

    initial begin
        int base;
        int quiet;
        int n;
        logic [7:0] c;

        rst = 1'b1;
        valid = 1'b0;
        data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Power-up: controller busy for 100 cycles after reset release.
        rst = 1'b0;
        base = strobes.size();
        quiet = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr || ready || done) quiet++;
        end
        chk("init_stall", quiet, 0);
        chk("init_stall_strobes", strobes.size() - base, 0);
        hold_busy = 1'b0;
        run_init("init");
        m_col = 0;
        m_line = 0;

        send_char(8'h41, 0);
        chk("print_A", strobes[strobes.size() - 1], 9'h141);
        chk("print_A_col", col, 1);

        send_char(8'h0C, 0);
        for (int i = 0; i < 16; i++) send_char(8'(8'h30 + i), 0);
        chk("wrap_addr1", strobes[strobes.size() - 1], 9'h0C0);
        chk("wrap_line1", line, 1);
        for (int i = 0; i < 16; i++) send_char(8'(8'h30 + i), 0);
        chk("wrap_addr0", strobes[strobes.size() - 1], 9'h080);
        chk("wrap_line0", line, 0);

        for (int i = 0; i < 5; i++) send_char(8'(8'h61 + i), 0);
        chk("ctl_col5", col, 5);
        send_char(8'h0A, 0);
        chk("nl_addr", strobes[strobes.size() - 1], 9'h0C0);
        send_char(8'h0D, 0);
        chk("cr_addr", strobes[strobes.size() - 1], 9'h0C0);
        send_char(8'h0C, 0);
        chk("ff_line", line, 0);

        send_char(8'h5A, 30);

        for (int i = 0; i < 80; i++) begin
            busy_len = int'($urandom_range(1, 8));
            n = int'($urandom_range(0, 9));
            if (n == 0) c = 8'h0A;
            else if (n == 1) c = 8'h0D;
            else if (n == 2) c = 8'h0C;
            else c = 8'($urandom_range(8'h20, 8'h7E));
            send_char(c, (n == 3) ? 5 : 0);
        end

        // Reset during the busy window of a data write.
        busy_len = 20;
        wait_ready();
        valid = 1'b1;
        data = 8'h51;
        @(negedge clk);
        valid = 1'b0;
        n = 0;
        while (wr !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midop_strobe", wr, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midop_reset");
        rst = 1'b0;
        run_init("reinit");
        m_col = 0;
        m_line = 0;
        chk("reinit_col", col, 0);
        chk("reinit_line", line, 0);
        repeat (30) @(negedge clk);
        send_char(8'h42, 0);

        chk("handshake_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
